// File: rtl/bus_router_pkg.sv
// Shared types and helpers for the bus_router slice.
// Contents: FSM state enum, default timeout, address region type,
// index-width helper and the 33-bit region hit test.
package bus_router_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] size;
  } region_t;

  // Slot index width; a single-slot build still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit keeps a region that ends exactly at 2^32 from wrapping.
  function automatic logic region_hit(input region_t r, input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] lo;
    logic [ADDR_W:0] hi;
    logic [ADDR_W:0] aa;
    lo = {1'b0, r.base};
    hi = lo + {1'b0, r.size};
    aa = {1'b0, a};
    return (r.size != '0) && (aa >= lo) && (aa < hi);
  endfunction

endpackage

// File: rtl/bus_router_decode.sv
// Combinational address decoder for bus_router.
// Ports: address (byte address in), hit (some enabled slot matches),
//        index (matching slot, lowest index wins on overlap).
module bus_router_decode
  import bus_router_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 8,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = '0,
  localparam int unsigned                 IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] address,
  output logic              hit,
  output logic [IDX_W-1:0]  index
);

  logic [NUM_SLAVES-1:0] slot_hit;

  // Per-slot range compare.
  for (genvar g = 0; g < int'(NUM_SLAVES); g++) begin : g_slot
    assign slot_hit[g] = region_hit(region_t'{base: SLAVE_BASE[g*ADDR_W +: ADDR_W],
                                              size: SLAVE_SIZE[g*ADDR_W +: ADDR_W]},
                                    address);
  end

  // Scan from the top so the lowest matching index is written last.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_router.sv
// Single-master to NUM_SLAVES bus router with address decode.
// Ports: i_clock/i_reset_n (async-assert, sync-release reset);
//   master side i_request/i_rw/i_address/i_wdata -> o_rdata/o_ready/o_error;
//   slave side o_slave_request (one-hot)/o_slave_rw/o_slave_address (offset)/
//   o_slave_wdata <- i_slave_rdata (packed)/i_slave_ready.
// Optional: define BUS_ROUTER_TIMEOUT_EN to abort ACTIVE after TIMEOUT cycles
// without ready; otherwise ACTIVE waits indefinitely.
module bus_router
  import bus_router_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 8,
  parameter int unsigned                  DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = '0,
  parameter int unsigned                  TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                         i_clock,
  input  logic                         i_reset_n,
  input  logic                         i_request,
  input  logic                         i_rw,
  input  logic [ADDR_W-1:0]            i_address,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_ready,
  output logic                         o_error,
  output logic [NUM_SLAVES-1:0]        o_slave_request,
  output logic                         o_slave_rw,
  output logic [ADDR_W-1:0]            o_slave_address,
  output logic [DATA_W-1:0]            o_slave_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_slave_rdata,
  input  logic [NUM_SLAVES-1:0]        i_slave_ready
);

  localparam int unsigned IDX_W = idx_width(NUM_SLAVES);

  // Reset release synchroniser; requests are ignored until it has filled.
  logic [1:0] rst_sync;
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  logic accept_en;
  assign accept_en = rst_sync[1];

  // Address decode.
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

  bus_router_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_SIZE (SLAVE_SIZE)
  ) u_decode (
    .address (i_address),
    .hit     (dec_hit),
    .index   (dec_idx)
  );

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [DATA_W-1:0]     rdata_d;
  logic                  ready_d;
  logic                  error_d;
  logic [NUM_SLAVES-1:0] sreq_d;
  logic                  srw_d;
  logic [ADDR_W-1:0]     saddr_d;
  logic [DATA_W-1:0]     swdata_d;

  // Base of the decoded slot, used to form the slave-relative offset.
  logic [ADDR_W-1:0] dec_base;
  always_comb begin
    dec_base = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (IDX_W'(i) == dec_idx) dec_base = SLAVE_BASE[i*ADDR_W +: ADDR_W];
    end
  end

  // Return path of the latched slot only; other slaves' ready is ignored.
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ready;
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (IDX_W'(i) == idx_q) begin
        sel_rdata = i_slave_rdata[i*DATA_W +: DATA_W];
        sel_ready = i_slave_ready[i];
      end
    end
  end

  logic [NUM_SLAVES-1:0] sel_onehot;
  assign sel_onehot = NUM_SLAVES'(1) << idx_q;

`ifdef BUS_ROUTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    error_d  = 1'b0;
    sreq_d   = o_slave_request;
    srw_d    = o_slave_rw;
    saddr_d  = o_slave_address;
    swdata_d = o_slave_wdata;
`ifdef BUS_ROUTER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        sreq_d = '0;
`ifdef BUS_ROUTER_TIMEOUT_EN
        cnt_d  = '0;
`endif
        if (i_request && accept_en) begin
          if (dec_hit) begin
            idx_d    = dec_idx;
            srw_d    = i_rw;
            saddr_d  = i_address - dec_base;
            swdata_d = i_wdata;
            state_d  = ACTIVE;
          end else begin
            state_d  = ERROR;
          end
        end
      end

      ACTIVE: begin
        if (!i_request) begin
          // Master withdrew: abort silently.
          sreq_d  = '0;
          state_d = IDLE;
        end else if ((o_slave_request != '0) && sel_ready) begin
          ready_d = 1'b1;
          rdata_d = o_slave_rw ? '0 : sel_rdata;
          sreq_d  = '0;
          state_d = DONE;
`ifdef BUS_ROUTER_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ready_d = 1'b1;
          error_d = 1'b1;
          sreq_d  = '0;
          state_d = DONE;
`endif
        end else begin
          // Slave request rises on the first ACTIVE cycle.
          sreq_d  = sel_onehot;
`ifdef BUS_ROUTER_TIMEOUT_EN
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end

      ERROR: begin
        ready_d = 1'b1;
        error_d = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        // Hold here until the master lets go so one request issues once.
        if (!i_request) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      o_rdata         <= '0;
      o_ready         <= 1'b0;
      o_error         <= 1'b0;
      o_slave_request <= '0;
      o_slave_rw      <= 1'b0;
      o_slave_address <= '0;
      o_slave_wdata   <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      o_rdata         <= rdata_d;
      o_ready         <= ready_d;
      o_error         <= error_d;
      o_slave_request <= sreq_d;
      o_slave_rw      <= srw_d;
      o_slave_address <= saddr_d;
      o_slave_wdata   <= swdata_d;
    end
  end

`ifdef BUS_ROUTER_TIMEOUT_EN
  // Wait-cycle counter for the selected slave.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_bus_router.sv
// Self-checking bench for bus_router (3-slot map, TIMEOUT=16).
// Builds with or without BUS_ROUTER_TIMEOUT_EN.
module tb_bus_router;

  localparam int unsigned NS  = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;
  localparam logic [NS*32-1:0] BASES = {32'h5000_0010, 32'h0001_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] SIZES = {32'h0000_0010, 32'h0001_0000, 32'h0001_0000};

  logic           clk;
  logic           rst_n;
  logic           i_request;
  logic           i_rw;
  logic [31:0]    i_address;
  logic [DW-1:0]  i_wdata;
  logic [DW-1:0]  o_rdata;
  logic           o_ready;
  logic           o_error;
  logic [NS-1:0]  o_slave_request;
  logic           o_slave_rw;
  logic [31:0]    o_slave_address;
  logic [DW-1:0]  o_slave_wdata;
  logic [NS*DW-1:0] i_slave_rdata;
  logic [NS-1:0]  i_slave_ready;

  bus_router #(
    .NUM_SLAVES (NS),
    .DATA_W     (DW),
    .SLAVE_BASE (BASES),
    .SLAVE_SIZE (SIZES),
    .TIMEOUT    (TMO)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_request       (i_request),
    .i_rw            (i_rw),
    .i_address       (i_address),
    .i_wdata         (i_wdata),
    .o_rdata         (o_rdata),
    .o_ready         (o_ready),
    .o_error         (o_error),
    .o_slave_request (o_slave_request),
    .o_slave_rw      (o_slave_rw),
    .o_slave_address (o_slave_address),
    .o_slave_wdata   (o_slave_wdata),
    .i_slave_rdata   (i_slave_rdata),
    .i_slave_ready   (i_slave_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Observations from the last drive_txn call.
  int          ob_lat;
  logic [2:0]  ob_req;
  logic [31:0] ob_saddr;
  logic [31:0] ob_swdata;
  logic        ob_srw;
  int          ob_pulses;
  int          ob_late_req;
  logic [31:0] ob_rdata;
  logic        ob_err;

  // Drive one master request and record what the DUT does. Latency is the
  // number of rising edges from request assertion to o_ready being visible.
  task automatic drive_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           input int rdy_slave, input int rdy_dly, input int budget,
                           input int hold_after);
    int cyc;
    int stop_at;
    ob_lat = -1; ob_req = '0; ob_saddr = '0; ob_swdata = '0; ob_srw = 1'b0;
    ob_pulses = 0; ob_late_req = 0; ob_rdata = '0; ob_err = 1'b0;
    stop_at = -1;
    @(posedge clk); #1;
    i_rw = rw; i_address = addr; i_wdata = wdata; i_request = 1'b1;
    if (rdy_slave >= 0 && rdy_dly == 0) i_slave_ready[rdy_slave] = 1'b1;
    cyc = 0;
    while (cyc < budget && (stop_at < 0 || cyc < stop_at)) begin
      @(posedge clk); #1;
      cyc++;
      if (o_slave_request != '0) begin
        if (ob_lat >= 0) ob_late_req++;
        else begin
          ob_req   = ob_req | o_slave_request;
          ob_saddr = o_slave_address;
          ob_swdata = o_slave_wdata;
          ob_srw   = o_slave_rw;
        end
      end
      if (o_ready) begin
        ob_pulses++;
        if (ob_lat < 0) begin
          ob_lat = cyc; ob_rdata = o_rdata; ob_err = o_error;
        end
      end
      if (rdy_slave >= 0 && cyc >= rdy_dly) i_slave_ready[rdy_slave] = 1'b1;
      if (ob_lat >= 0 && cyc == ob_lat + hold_after) begin
        i_request = 1'b0; i_slave_ready = '0; stop_at = cyc + 3;
      end
    end
    i_request = 1'b0; i_slave_ready = '0; i_rw = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard entry for a completed transfer and compare.
  task automatic check_completion(input string name);
    exp_t e;
    tests++;
    if (ob_lat < 0 || sb.size() == 0) begin
      fails++;
      $display("FAIL %s no_completion: lat=%0d queued=%0d", name, ob_lat, sb.size());
    end else begin
      e = sb.pop_front();
      if (ob_rdata !== e.rdata || ob_err !== e.err) begin
        fails++;
        $display("FAIL %s response: rdata=%h err=%b required rdata=%h err=%b",
                 name, ob_rdata, ob_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset();
    int first;
    rst_n = 1'b0; i_request = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
    i_slave_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_rdata, o_ready, o_error, o_slave_request, o_slave_rw, o_slave_address, o_slave_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b err=%b req=%b addr=%h required all zero",
               o_ready, o_error, o_slave_request, o_slave_address);
    end
    // Release and request an unmapped address immediately.
    rst_n = 1'b1;
    i_address = 32'h3000_0000; i_request = 1'b1;
    sb.push_back('{rdata: '0, err: 1'b1});
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (o_ready && first < 0) begin
        first = c; ob_rdata = o_rdata; ob_err = o_error;
      end
    end
    i_request = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (first < 3) begin
      fails++;
      $display("FAIL reset_release_accept: o_ready at edge %0d, required >= 3", first);
    end
    ob_lat = first;
    check_completion("reset_release");
  endtask

  task automatic test_read();
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    drive_txn(1'b0, 32'h0001_0004, '0, 1, 2, 50, 0);
    tests++;
    if (ob_req !== 3'b010 || ob_saddr !== 32'h4 || ob_srw !== 1'b0) begin
      fails++;
      $display("FAIL read_slave_side: req=%b addr=%h rw=%b required 010/00000004/0",
               ob_req, ob_saddr, ob_srw);
    end
    tests++;
    if (ob_pulses !== 1 || ob_lat !== 3) begin
      fails++;
      $display("FAIL read_pulse: pulses=%0d lat=%0d required 1/3", ob_pulses, ob_lat);
    end
    check_completion("read");
  endtask

  task automatic test_write();
    sb.push_back('{rdata: '0, err: 1'b0});
    drive_txn(1'b1, 32'h5000_0014, 32'h41, 2, 0, 50, 0);
    tests++;
    if (ob_req !== 3'b100 || ob_saddr !== 32'h4 || ob_swdata !== 32'h41 || ob_srw !== 1'b1) begin
      fails++;
      $display("FAIL write_slave_side: req=%b addr=%h wdata=%h rw=%b required 100/4/41/1",
               ob_req, ob_saddr, ob_swdata, ob_srw);
    end
    tests++;
    if (ob_pulses !== 1 || ob_lat !== 3) begin
      fails++;
      $display("FAIL write_pulse: pulses=%0d lat=%0d required 1/3", ob_pulses, ob_lat);
    end
    check_completion("write");
  endtask

  task automatic test_unmapped();
    sb.push_back('{rdata: '0, err: 1'b1});
    drive_txn(1'b0, 32'h3000_0000, '0, -1, 0, 50, 0);
    tests++;
    if (ob_req !== 3'b000 || ob_lat !== 2 || ob_pulses !== 1) begin
      fails++;
      $display("FAIL unmapped: req=%b lat=%0d pulses=%0d required 000/2/1", ob_req, ob_lat, ob_pulses);
    end
    check_completion("unmapped");
  endtask

  task automatic test_boundary();
    // Last byte of slot2 hits; first byte past it does not.
    sb.push_back('{rdata: 32'h2222_2222, err: 1'b0});
    drive_txn(1'b0, 32'h5000_001F, '0, 2, 0, 50, 0);
    tests++;
    if (ob_req !== 3'b100 || ob_saddr !== 32'hF) begin
      fails++;
      $display("FAIL boundary_last: req=%b addr=%h required 100/0000000f", ob_req, ob_saddr);
    end
    check_completion("boundary_last");
    sb.push_back('{rdata: '0, err: 1'b1});
    drive_txn(1'b0, 32'h5000_0020, '0, -1, 0, 50, 0);
    tests++;
    if (ob_req !== 3'b000 || ob_lat !== 2) begin
      fails++;
      $display("FAIL boundary_past: req=%b lat=%0d required 000/2", ob_req, ob_lat);
    end
    check_completion("boundary_past");
    sb.push_back('{rdata: 32'h1111_1111, err: 1'b0});
    drive_txn(1'b0, 32'h0001_FFFF, '0, 1, 0, 50, 0);
    tests++;
    if (ob_req !== 3'b010 || ob_saddr !== 32'hFFFF) begin
      fails++;
      $display("FAIL boundary_slot1_end: req=%b addr=%h required 010/0000ffff", ob_req, ob_saddr);
    end
    // Slot1 returns CAFEF00D, not slot0's data.
    sb[0].rdata = 32'hCAFE_F00D;
    check_completion("boundary_slot1_end");
  endtask

  task automatic test_ignore_other_ready();
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    i_slave_ready = 3'b101;
    drive_txn(1'b0, 32'h0001_0010, '0, 1, 4, 50, 0);
    tests++;
    if (ob_lat !== 5 || ob_pulses !== 1) begin
      fails++;
      $display("FAIL ignore_other_ready: lat=%0d pulses=%0d required 5/1", ob_lat, ob_pulses);
    end
    check_completion("ignore_other_ready");
  endtask

  task automatic test_timeout();
`ifdef BUS_ROUTER_TIMEOUT_EN
    sb.push_back('{rdata: '0, err: 1'b1});
    drive_txn(1'b0, 32'h0001_0004, '0, -1, 0, 100, 0);
    tests++;
    if (ob_lat !== int'(TMO) + 1 || ob_pulses !== 1 || ob_req !== 3'b010) begin
      fails++;
      $display("FAIL timeout: lat=%0d pulses=%0d req=%b required %0d/1/010",
               ob_lat, ob_pulses, ob_req, TMO + 1);
    end
    check_completion("timeout");
`else
    drive_txn(1'b0, 32'h0001_0004, '0, -1, 0, 1000, 0);
    tests++;
    if (ob_pulses !== 0 || ob_req !== 3'b010) begin
      fails++;
      $display("FAIL no_timeout: pulses=%0d req=%b required 0/010", ob_pulses, ob_req);
    end
    // drive_txn dropped the request at the end: the transfer aborted.
    tests++;
    if (o_slave_request !== 3'b000 || o_ready !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout_abort: req=%b ready=%b required 000/0", o_slave_request, o_ready);
    end
`endif
  endtask

  task automatic test_abort();
    int pulses;
    @(posedge clk); #1;
    i_address = 32'h0000_0100; i_rw = 1'b0; i_request = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    i_request = 1'b0;
    pulses = 0;
    @(posedge clk); #1;
    tests++;
    if (o_slave_request !== 3'b000) begin
      fails++;
      $display("FAIL abort_drop: req=%b required 000", o_slave_request);
    end
    for (int c = 0; c < 5; c++) begin
      if (o_ready) pulses++;
      @(posedge clk); #1;
    end
    tests++;
    if (pulses !== 0) begin
      fails++;
      $display("FAIL abort_no_ready: pulses=%0d required 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    i_address = 32'h0001_0004; i_rw = 1'b0; i_request = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (o_slave_request !== 3'b010) begin
      fails++;
      $display("FAIL reset_mid_pre: req=%b required 010", o_slave_request);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({o_rdata, o_ready, o_error, o_slave_request, o_slave_rw, o_slave_address, o_slave_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: req=%b addr=%h ready=%b required all zero",
               o_slave_request, o_slave_address, o_ready);
    end
    i_request = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0});
    drive_txn(1'b0, 32'h0001_0004, '0, 1, 2, 50, 0);
    tests++;
    if (ob_lat !== 3 || ob_saddr !== 32'h4) begin
      fails++;
      $display("FAIL reset_mid_after: lat=%0d addr=%h required 3/00000004", ob_lat, ob_saddr);
    end
    check_completion("reset_mid_after");
  endtask

  task automatic test_back_to_back();
    sb.push_back('{rdata: 32'h2222_2222, err: 1'b0});
    drive_txn(1'b0, 32'h5000_0010, '0, 2, 0, 50, 5);
    tests++;
    if (ob_late_req !== 0 || ob_pulses !== 1) begin
      fails++;
      $display("FAIL held_request: late_req=%0d pulses=%0d required 0/1", ob_late_req, ob_pulses);
    end
    check_completion("held_request");
    sb.push_back('{rdata: 32'h1111_1111, err: 1'b0});
    drive_txn(1'b0, 32'h0000_0008, '0, 0, 0, 50, 0);
    tests++;
    if (ob_req !== 3'b001 || ob_saddr !== 32'h8 || ob_lat !== 3) begin
      fails++;
      $display("FAIL next_after_held: req=%b addr=%h lat=%0d required 001/8/3",
               ob_req, ob_saddr, ob_lat);
    end
    check_completion("next_after_held");
  endtask

  initial begin
    i_slave_rdata = {32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_boundary();
    test_ignore_other_ready();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
